// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared constants for the DMEM load/store unit: RV32I width/sign
//           codes, FSM state encoding and DMEM word geometry.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I funct3 width/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // DMEM is word-only; every access touches one 4-byte word
    localparam int DMEM_WORD_BYTES = 4;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Unused funct3 codes, and unsigned widths on stores, are not legal accesses
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (we && ((f3 == F3_BU) || (f3 == F3_HU))) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational lane logic for the load/store unit. Extracts and
//           extends the addressed byte/half of a DMEM word for loads, and
//           merges store data into a read word for sub-word stores.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane selection: byte k at bits [8k+7:8k], half at addr[1]
    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    // Load value: sign- or zero-extend the selected lane
    always_comb begin
        o_load = 32'h0;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_W:    o_load = i_word;
            F3_BU:   o_load = {24'h0, w_byte};
            F3_HU:   o_load = {16'h0, w_half};
            default: o_load = 32'h0;
        endcase
    end

    // Store word: replace only the addressed lane(s); full words pass straight through
    always_comb begin
        o_store = i_word;
        case (i_funct3)
            F3_B:    o_store[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
            F3_H:    o_store[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_store = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lsu
// Brief   : Load/store initiator between the CPU datapath and a word-only
//           DMEM. Handles byte/half/word loads and stores, using
//           read-modify-write for sub-word stores, and rejects illegal,
//           misaligned or out-of-range accesses without touching memory.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    // One past the last legal byte address; 33 bits so the limit cannot wrap
    localparam logic [32:0] c_MEM_BYTES = 33'(MEM_WORDS * DMEM_WORD_BYTES);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_err;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_store;

    // Request checks evaluated on the live inputs so the verdict is captured at accept
    always_comb begin
        w_illegal      = f3_illegal(we, funct3);
        w_misaligned   = ((funct3 == F3_H) || (funct3 == F3_HU)) ? addr[0]
                       : (funct3 == F3_W) ? (addr[1:0] != 2'b00)
                       : 1'b0;
        w_out_of_range = ({1'b0, addr} >= c_MEM_BYTES);
        w_fault        = w_illegal || w_misaligned || w_out_of_range;
    end

    // Next-state: sub-word stores read first, full-word stores write directly
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_fault) begin
                        w_next_state = S_DONE;
                    end else if (we && (funct3 == F3_W)) begin
                        w_next_state = S_WR;
                    end else begin
                        w_next_state = S_RD;
                    end
                end
            end
            S_RD:    w_next_state = r_we ? S_WR : S_DONE;
            S_WR:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset drops any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the request at accept and the DMEM word at the end of RD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_word   <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && req) begin
                r_we     <= we;
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_err    <= w_fault;
            end
            if (r_state == S_RD) begin
                r_word <= readData;
            end
        end
    end

    lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (r_word),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_store   (w_store)
    );

    // Moore outputs from state and captured request; buses idle at zero
    always_comb begin
        ready     = (r_state == S_IDLE);
        done      = (r_state == S_DONE);
        err       = (r_state == S_DONE) && r_err;
        rdata     = ((r_state == S_DONE) && !r_we && !r_err) ? w_load : 32'h0;
        MemRead   = (r_state == S_RD);
        MemWrite  = (r_state == S_WR);
        Address   = ((r_state == S_RD) || (r_state == S_WR)) ? {r_addr[31:2], 2'b00} : 32'h0;
        writeData = (r_state == S_WR) ? w_store : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_lsu
// Brief   : Self-checking bench for dmem_lsu with a DMEM model, a byte-level
//           reference memory and a scoreboard monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    localparam int MEM_WORDS = 64;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] writeData;
    logic [31:0] readData;

    logic [31:0] mem      [MEM_WORDS];
    logic [31:0] init_val [MEM_WORDS];
    logic [31:0] ref_mem  [MEM_WORDS];
    logic        load_mem;

    exp_t q[$];
    int   done_cycles[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_edge = 0;
    int   rd_cnt  = 0;
    int   wr_cnt  = 0;

    dmem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .writeData (writeData),
        .readData  (readData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DMEM model: combinational read, write on the rising edge
    assign readData = MemRead ? mem[Address[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val[i];
        end else if (MemWrite) begin
            mem[Address[7:2]] <= writeData;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the access rules to a plain word array
    function automatic exp_t model(input logic w, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic        bad;
        int          idx;
        int          bsh;
        int          hsh;
        logic [31:0] old;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] nw;
        bad = (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && (f3 == 4 || f3 == 5))
            || ((f3 == 1 || f3 == 5) && (a % 2 != 0))
            || (f3 == 2 && (a % 4 != 0))
            || (a >= MEM_WORDS * 4);
        e.err = bad; e.rdata = 0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.waddr = 0; e.wdata = 0;
        if (bad) return e;
        idx = int'(a / 4);
        bsh = 8 * int'(a % 4);
        hsh = 16 * int'((a % 4) / 2);
        old = ref_mem[idx];
        b   = (old >> bsh) & 32'hFF;
        h   = (old >> hsh) & 32'hFFFF;
        if (!w) begin
            e.nrd = 1; e.lat = 2;
            case (f3)
                3'd0:    e.rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd1:    e.rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd2:    e.rdata = old;
                3'd4:    e.rdata = b;
                default: e.rdata = h;
            endcase
        end else begin
            if (f3 == 2) begin
                e.nwr = 1; e.lat = 2; nw = d;
            end else if (f3 == 0) begin
                e.nrd = 1; e.nwr = 1; e.lat = 3;
                nw = (old & ~(32'hFF << bsh)) | ((d & 32'hFF) << bsh);
            end else begin
                e.nrd = 1; e.nwr = 1; e.lat = 3;
                nw = (old & ~(32'hFFFF << hsh)) | ((d & 32'hFFFF) << hsh);
            end
            ref_mem[idx] = nw;
            e.waddr = idx * 4;
            e.wdata = nw;
        end
        return e;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL wait_ready: got ready=0 expected ready=1 within 20 cycles");
        end
    endtask

    // Present one request in an IDLE cycle; expected response goes to the scoreboard
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        we = w; funct3 = f3; addr = a; wdata = d; req = 1'b1;
        q.push_back(model(w, f3, a, d));
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0 && ready) return;
            @(posedge clk); #1;
        end
        n_tests++; n_fail++;
        $display("FAIL drain: got %0d pending expected 0 pending", q.size());
    endtask

    // Monitor: counts bus activity per access and scores every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (req && ready) acc_edge = cyc + 1;
            if (MemRead) rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got MemWrite=1 addr 0x%08h expected MemWrite=0", Address);
                end else begin
                    check("write_addr", Address, q[0].waddr);
                    check("write_data", writeData, q[0].wdata);
                end
            end
            if (done) begin
                done_cycles.push_back(cyc);
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    e = q.pop_front();
                    check("err", 32'(err), 32'(e.err));
                    check("rdata", rdata, e.rdata);
                    check("latency", 32'(cyc - acc_edge + 1), 32'(e.lat));
                    check("memread_cycles", 32'(rd_cnt), 32'(e.nrd));
                    check("memwrite_cycles", 32'(wr_cnt), 32'(e.nwr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        load_mem = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            init_val[i] = $urandom;
            ref_mem[i]  = init_val[i];
        end
        repeat (2) @(posedge clk);
        #1;
        load_mem = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_memread", 32'(MemRead), 32'd0);
        check("reset_memwrite", 32'(MemWrite), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_address", Address, 32'h0);
        check("reset_writedata", writeData, 32'h0);
        reset = 1'b0;

        // Directed sequence
        issue(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'h11, 32'h0000_00AA, 1'b0);
        issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h12, 32'h0000_8001, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0E, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h13, 32'hBEEF, 1'b0);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 3'b100, 32'h20, 32'h55, 1'b0);
        drain();

        // Reset while an SB sits in its read phase: no write may follow
        begin
            bit ok;
            wait_ready(ok);
            we = 1'b1; funct3 = 3'b000; addr = 32'h21; wdata = 32'h77; req = 1'b1;
            @(posedge clk); #1;
            req = 1'b0;
            check("abort_in_rd", 32'(MemRead), 32'd1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("abort_ready", 32'(ready), 32'd1);
            check("abort_memwrite", 32'(MemWrite), 32'd0);
            repeat (4) @(posedge clk);
        end

        // Back-to-back word loads with req held high
        drain();
        done_cycles.delete();
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h18, 32'h0, 1'b0);
        drain();
        check("b2b_done_count", 32'(done_cycles.size()), 32'd3);
        if (done_cycles.size() == 3) begin
            check("b2b_spacing_1", 32'(done_cycles[1] - done_cycles[0]), 32'd3);
            check("b2b_spacing_2", 32'(done_cycles[2] - done_cycles[1]), 32'd3);
        end

        // Randomized accesses, mostly in range, with illegal and misaligned mixed in
        for (int i = 0; i < 80; i++) begin
            logic        rw;
            logic [2:0]  rf;
            logic [31:0] ra;
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            ra = 32'($urandom_range(0, 280));
            issue(rw, rf, ra, $urandom, 1'b0);
        end
        drain();

        // DMEM contents must match the reference image
        for (int i = 0; i < MEM_WORDS; i++) begin
            check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
